flash_bus_responder: RTL

//  Responder end of the flash bus driven by the command manager FSM.

---
 rtl/flash_bus_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/flash_bus_responder.sv
// Flash bus responder: emulates NOR-flash read/program/sector-erase timing
// over a 256x8 internal array. Each accepted request produces one fb_done
// strobe; protected program/erase requests complete at once with err set.
module flash_bus_responder #(
    parameter int unsigned READ_WAIT  = 4,
    parameter int unsigned WRITE_WAIT = 20,
    parameter int unsigned ERASE_WAIT = 100,
    parameter logic [7:0]  WP_BASE    = 8'hF0
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       fb_start,
    input  logic       fl_flow,
    input  logic       fl_erase,
    input  logic [7:0] fl_addr,
    input  logic [7:0] fl_data_wr,
    output logic [7:0] fl_data_rd,
    output logic       fb_done,
    output logic       busy,
    output logic       err
);

    // Wait counter must hold the largest reload value (MAX_WAIT - 1).
    localparam int unsigned MAX_RW   = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned MAX_WAIT = (MAX_RW > ERASE_WAIT) ? MAX_RW : ERASE_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] ER_LOAD = CNT_W'(ERASE_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StWrWait,
        StErWait,
        StErClr,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       clr_off_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;

    // Configuration-time contents are all ones (erased flash); RST does not touch them.
    logic [7:0] mem [256] = '{default: 8'hFF};

    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;

    logic       start_prog_prot;
    logic       start_erase_prot;

    assign start_prog_prot  = (fl_addr >= WP_BASE);
    assign start_erase_prot = ({fl_addr[7:4], 4'h0} >= WP_BASE);

    // Storage write port: program update at the end of WR_WAIT, one byte per ER_CLR cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = 8'hFF;
        if (!RST) begin
            unique case (state_q)
                StWrWait: begin
                    if (cnt_q == '0) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_q;
                        // Programming can only clear bits.
                        mem_wdata = mem[addr_q] & data_q;
                    end
                end
                StErClr: begin
                    mem_we    = 1'b1;
                    mem_waddr = {addr_q[7:4], clr_off_q};
                    mem_wdata = 8'hFF;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // Storage array, not reset so partial erases survive RST.
    always_ff @(posedge CLK_50MHZ) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Request FSM with registered outputs.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_off_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            fl_data_rd <= '0;
            fb_done    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            fb_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fb_start) begin
                        addr_q    <= fl_addr;
                        data_q    <= fl_data_wr;
                        clr_off_q <= '0;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        // Erase takes priority over the read/program select.
                        if (fl_erase) begin
                            if (start_erase_prot) begin
                                state_q <= StDone;
                                fb_done <= 1'b1;
                                err     <= 1'b1;
                            end else begin
                                state_q <= StErWait;
                                cnt_q   <= ER_LOAD;
                            end
                        end else if (fl_flow) begin
                            if (start_prog_prot) begin
                                state_q <= StDone;
                                fb_done <= 1'b1;
                                err     <= 1'b1;
                            end else begin
                                state_q <= StWrWait;
                                cnt_q   <= WR_LOAD;
                            end
                        end else begin
                            state_q <= StRdWait;
                            cnt_q   <= RD_LOAD;
                        end
                    end
                end
                StRdWait: begin
                    if (cnt_q == '0) begin
                        fl_data_rd <= mem[addr_q];
                        fb_done    <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StWrWait: begin
                    if (cnt_q == '0) begin
                        fb_done <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StErWait: begin
                    if (cnt_q == '0) begin
                        clr_off_q <= '0;
                        state_q   <= StErClr;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StErClr: begin
                    // Offset stops at 15; the last byte is written on the way out.
                    if (clr_off_q == 4'hF) begin
                        fb_done <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        clr_off_q <= clr_off_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule
